mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 23 ++
 rtl/mux_arbiter.sv | 121 ++++++++++++
 tb/tb_mux_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and grant-to-source helper for mux_arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 4;
    localparam int SRC_W   = 2;
    localparam int CNT_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Requester number (1..NUM_REQ) of a one-hot grant; 0 when nothing is granted.
    function automatic logic [SRC_W-1:0] gnt_to_src(input logic [NUM_REQ-1:0] oh);
        logic [SRC_W-1:0] src;
        case (oh)
            3'b001:  src = 2'd1;
            3'b010:  src = 2'd2;
            3'b100:  src = 2'd3;
            default: src = 2'd0;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting index strictly after last_gnt, wrapping,
// so the previous winner itself has the lowest priority.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last_gnt,
    output logic [NUM_REQ-1:0] next_gnt
);

    logic [NUM_REQ-1:0] above;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pool;

    always_comb begin
        // Bits strictly above the one-hot last grant; empty when last_gnt is the top bit.
        above    = ~((last_gnt << 1) - NUM_REQ'(1));
        masked   = req & above;
        pool     = (masked != '0) ? masked : req;
        next_gnt = pool & (~pool + NUM_REQ'(1));
    end

endmodule

// File: rtl/mux_arbiter.sv
// Three-requester round-robin arbiter with bounded bursts and a registered
// data mux that presents the granted requester's data one cycle after the grant.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  in1,
    input  logic [DATA_W-1:0]  in2,
    input  logic [DATA_W-1:0]  in3,
    output logic [NUM_REQ-1:0] gnt,
    output logic               sel1,
    output logic               sel2,
    output logic               sel3,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [SRC_W-1:0]   out_src,
    output state_t             dbg_state
);

    // Handshake: req[k] is a level request sampled at every rising edge; gnt[k]
    // is the registered answer and is only ever set while req[k] was high at
    // that edge. There is no back-pressure: out_valid qualifies out_data/out_src.

    localparam logic [CNT_W-1:0]   BURST_LIM = CNT_W'(BURST_MAX);
    localparam logic [NUM_REQ-1:0] LAST_RST  = {1'b1, {(NUM_REQ-1){1'b0}}};

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [CNT_W-1:0]   burst_cnt, cnt_nxt;
    logic [NUM_REQ-1:0] last_gnt, last_nxt;
    logic [NUM_REQ-1:0] pick;
    logic               hold;
    logic [DATA_W-1:0]  data_nxt;

    rr_pick u_rr_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .next_gnt (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            burst_cnt <= '0;
            last_gnt  <= LAST_RST;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_src   <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            burst_cnt <= cnt_nxt;
            last_gnt  <= last_nxt;
            out_data  <= data_nxt;
            out_valid <= (gnt != '0);
            out_src   <= gnt_to_src(gnt);
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        cnt_nxt   = burst_cnt;
        last_nxt  = last_gnt;
        hold      = 1'b0;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_nxt = BUSY;
                    gnt_nxt   = pick;
                    cnt_nxt   = CNT_W'(1);
                    last_nxt  = pick;
                end
            end
            BUSY: begin
                hold = ((gnt & req) != '0) && (burst_cnt < BURST_LIM);
                if (hold) begin
                    cnt_nxt = burst_cnt + CNT_W'(1);
                end else if (req != '0) begin
                    // Hand over on the release edge itself; a lone requester is re-granted.
                    gnt_nxt  = pick;
                    cnt_nxt  = CNT_W'(1);
                    last_nxt = pick;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_comb begin
        case (gnt)
            3'b001:  data_nxt = in1;
            3'b010:  data_nxt = in2;
            3'b100:  data_nxt = in3;
            default: data_nxt = '0;
        endcase
    end

    assign sel1      = gnt[0];
    assign sel2      = gnt[1];
    assign sel3      = gnt[2];
    assign dbg_state = state;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_burst_bound: assert property (@(posedge clk) disable iff (!rst_n) burst_cnt <= BURST_LIM);
    a_data1: assert property (@(posedge clk) disable iff (!rst_n)
        gnt[0] |=> (out_valid && out_src == 2'd1 && out_data == $past(in1)));
    a_data2: assert property (@(posedge clk) disable iff (!rst_n)
        gnt[1] |=> (out_valid && out_src == 2'd2 && out_data == $past(in2)));
    a_data3: assert property (@(posedge clk) disable iff (!rst_n)
        gnt[2] |=> (out_valid && out_src == 2'd3 && out_data == $past(in3)));

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter at BURST_MAX 4, 2 and 1 side by side: behavioural model
// checked every cycle, pinned by hand-computed directed expectations.
module tb_mux_arbiter;
    import mux_arb_pkg::*;

    localparam int NI = 3;

    typedef struct packed {
        logic [1:0] owner;  // requester number holding the grant, 0 = none
        logic [3:0] cnt;    // cycles the owner has held the current burst
        logic [1:0] last;   // requester number of the most recent grant
        logic [3:0] data;
        logic       valid;
        logic [1:0] src;
    } mdl_t;

    localparam mdl_t MDL_RST = '{owner: 2'd0, cnt: 4'd0, last: 2'd3,
                                 data: 4'd0, valid: 1'b0, src: 2'd0};

    logic         clk;
    logic         rst_n;
    logic [2:0]   req;
    logic [3:0]   in1, in2, in3;
    logic [2:0]   gnt_o   [NI];
    logic         sel1_o  [NI];
    logic         sel2_o  [NI];
    logic         sel3_o  [NI];
    logic [3:0]   data_o  [NI];
    logic         valid_o [NI];
    logic [1:0]   src_o   [NI];
    state_t       st_o    [NI];

    mdl_t         m [NI];
    int           wait_c [NI][3];
    int           errors;
    int           checks;

    logic [2:0]   exp_b_g4 [8];
    logic [2:0]   exp_b_g2 [8];
    logic [2:0]   exp_b_g1 [8];
    logic [1:0]   exp_b_s2 [8];

    mux_arbiter #(.BURST_MAX(4)) u_bm4 (
        .clk(clk), .rst_n(rst_n), .req(req), .in1(in1), .in2(in2), .in3(in3),
        .gnt(gnt_o[0]), .sel1(sel1_o[0]), .sel2(sel2_o[0]), .sel3(sel3_o[0]),
        .out_data(data_o[0]), .out_valid(valid_o[0]), .out_src(src_o[0]),
        .dbg_state(st_o[0])
    );

    mux_arbiter #(.BURST_MAX(2)) u_bm2 (
        .clk(clk), .rst_n(rst_n), .req(req), .in1(in1), .in2(in2), .in3(in3),
        .gnt(gnt_o[1]), .sel1(sel1_o[1]), .sel2(sel2_o[1]), .sel3(sel3_o[1]),
        .out_data(data_o[1]), .out_valid(valid_o[1]), .out_src(src_o[1]),
        .dbg_state(st_o[1])
    );

    mux_arbiter #(.BURST_MAX(1)) u_bm1 (
        .clk(clk), .rst_n(rst_n), .req(req), .in1(in1), .in2(in2), .in3(in3),
        .gnt(gnt_o[2]), .sel1(sel1_o[2]), .sel2(sel2_o[2]), .sel3(sel3_o[2]),
        .out_data(data_o[2]), .out_valid(valid_o[2]), .out_src(src_o[2]),
        .dbg_state(st_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int bm_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 1;
    endfunction

    function automatic logic req_of(input logic [2:0] r, input int k);
        return (k >= 1 && k <= 3) ? r[k-1] : 1'b0;
    endfunction

    function automatic logic [2:0] oh_of(input int k);
        return (k >= 1 && k <= 3) ? 3'(1 << (k - 1)) : 3'b000;
    endfunction

    // One clock edge of the arbiter, written from its rules: the data stage
    // shows whoever owned the previous cycle; the owner keeps going while it
    // still asks and is under its burst limit, otherwise the first asking
    // requester after the last one granted (cyclically, itself last) takes over.
    function automatic mdl_t model_next(input mdl_t s, input logic [2:0] r,
                                        input logic [3:0] d1, input logic [3:0] d2,
                                        input logic [3:0] d3, input int bm);
        mdl_t n;
        int   cand;
        n       = s;
        n.valid = (s.owner != 2'd0);
        n.src   = s.owner;
        case (s.owner)
            2'd1:    n.data = d1;
            2'd2:    n.data = d2;
            2'd3:    n.data = d3;
            default: n.data = 4'd0;
        endcase
        if (s.owner != 2'd0 && req_of(r, int'(s.owner)) && int'(s.cnt) < bm) begin
            n.cnt = s.cnt + 4'd1;
        end else begin
            n.owner = 2'd0;
            n.cnt   = 4'd0;
            for (int c = 3; c >= 1; c--) begin
                cand = ((int'(s.last) + c - 1) % 3) + 1;
                if (req_of(r, cand)) begin
                    n.owner = 2'(cand);
                    n.cnt   = 4'd1;
                    n.last  = 2'(cand);
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("gnt bm%0d", bm_of(i)), 8'(gnt_o[i]), 8'(oh_of(int'(m[i].owner))));
            chk($sformatf("sel bm%0d", bm_of(i)), {5'b0, sel3_o[i], sel2_o[i], sel1_o[i]},
                8'(oh_of(int'(m[i].owner))));
            chk($sformatf("out_data bm%0d", bm_of(i)), 8'(data_o[i]), 8'(m[i].data));
            chk($sformatf("out_valid bm%0d", bm_of(i)), 8'(valid_o[i]), 8'(m[i].valid));
            chk($sformatf("out_src bm%0d", bm_of(i)), 8'(src_o[i]), 8'(m[i].src));
            chk($sformatf("state bm%0d", bm_of(i)), 8'(st_o[i]),
                (m[i].owner != 2'd0) ? 8'(BUSY) : 8'(IDLE));
            for (int k = 0; k < 3; k++) begin
                if (!rst_n || !req[k]) begin
                    wait_c[i][k] = 0;
                end else if (gnt_o[i][k]) begin
                    checks++;
                    if (wait_c[i][k] > 2 * bm_of(i)) begin
                        errors++;
                        $display("FAIL fairness bm%0d req%0d: waited %0d cycles, limit %0d",
                                 bm_of(i), k + 1, wait_c[i][k], 2 * bm_of(i));
                    end
                    wait_c[i][k] = 0;
                end else begin
                    wait_c[i][k]++;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m[i] = MDL_RST;
            for (int k = 0; k < 3; k++) wait_c[i][k] = 0;
        end
    endtask

    // Called at a falling edge (or time 0); returns at a falling edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        in1   = 4'd0;
        in2   = 4'd0;
        in3   = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive at a falling edge, advance one rising edge, check, return at the next falling edge.
    task automatic step(input logic [2:0] r, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c);
        req = r;
        in1 = a;
        in2 = b;
        in3 = c;
        @(posedge clk);
        for (int i = 0; i < NI; i++) m[i] = model_next(m[i], req, in1, in2, in3, bm_of(i));
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] r;
        errors = 0;
        checks = 0;
        exp_b_g4 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010};
        exp_b_g2 = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
        exp_b_g1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        exp_b_s2 = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};

        do_reset();
        chk("reset gnt", 8'(gnt_o[0]), 8'h00);
        chk("reset valid", 8'(valid_o[0]), 8'h00);
        chk("reset state", 8'(st_o[0]), 8'(IDLE));

        // Lone requester 1 for six cycles: burst of 4 then seamless re-grant.
        for (int i = 0; i < 6; i++) begin
            step(3'b001, 4'(i + 5), 4'hA, 4'hB);
            chk("solo gnt", 8'(gnt_o[0]), 8'h01);
            if (i > 0) chk("solo data", 8'(data_o[0]), 8'(i + 5));
        end
        step(3'b000, 4'hC, 4'hA, 4'hB);
        chk("solo drop gnt", 8'(gnt_o[0]), 8'h00);
        chk("solo drop data", 8'(data_o[0]), 8'h0C);
        step(3'b000, 4'h0, 4'h0, 4'h0);
        chk("solo idle valid", 8'(valid_o[0]), 8'h00);

        // All three requesting: rotation at each burst length.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(3'b111, 4'h1, 4'h2, 4'h3);
            chk("rot gnt bm4", 8'(gnt_o[0]), 8'(exp_b_g4[i]));
            chk("rot gnt bm2", 8'(gnt_o[1]), 8'(exp_b_g2[i]));
            chk("rot gnt bm1", 8'(gnt_o[2]), 8'(exp_b_g1[i]));
            chk("rot src bm2", 8'(src_o[1]), 8'(exp_b_s2[i]));
        end

        // Requester 2 granted, then every request drops.
        do_reset();
        step(3'b010, 4'h1, 4'h7, 4'h3);
        chk("drop gnt0", 8'(gnt_o[0]), 8'h02);
        step(3'b000, 4'h1, 4'h8, 4'h3);
        chk("drop gnt1", 8'(gnt_o[0]), 8'h00);
        chk("drop valid1", 8'(valid_o[0]), 8'h01);
        chk("drop src1", 8'(src_o[0]), 8'h02);
        chk("drop data1", 8'(data_o[0]), 8'h08);
        step(3'b000, 4'h1, 4'h9, 4'h3);
        chk("drop valid2", 8'(valid_o[0]), 8'h00);
        chk("drop src2", 8'(src_o[0]), 8'h00);

        // Requester 3 mid-burst, requester 1 waiting, requester 3 drops: no bubble.
        do_reset();
        step(3'b100, 4'h1, 4'h2, 4'h6);
        step(3'b101, 4'h1, 4'h2, 4'h6);
        chk("handover pre gnt", 8'(gnt_o[0]), 8'h04);
        step(3'b001, 4'h4, 4'h2, 4'h6);
        chk("handover gnt", 8'(gnt_o[0]), 8'h01);
        chk("handover valid", 8'(valid_o[0]), 8'h01);
        chk("handover src", 8'(src_o[0]), 8'h03);
        step(3'b000, 4'h5, 4'h2, 4'h6);
        chk("handover data", 8'(data_o[0]), 8'h05);

        // Asynchronous reset in the middle of a burst of requester 2.
        do_reset();
        step(3'b010, 4'h1, 4'hD, 4'h3);
        step(3'b010, 4'h1, 4'hE, 4'h3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async gnt", 8'(gnt_o[0]), 8'h00);
        chk("async sel2", 8'(sel2_o[0]), 8'h00);
        chk("async valid", 8'(valid_o[0]), 8'h00);
        chk("async data", 8'(data_o[0]), 8'h00);
        chk("async src", 8'(src_o[0]), 8'h00);
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 3'b000;
        step(3'b110, 4'h1, 4'h2, 4'h3);
        chk("post reset gnt bm4", 8'(gnt_o[0]), 8'h02);
        chk("post reset gnt bm1", 8'(gnt_o[2]), 8'h02);

        // Random traffic; requests persist for a few cycles at a time.
        do_reset();
        r = 3'b000;
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            step(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
